// File: rtl/i2c_target_responder.sv
// ---------------------------------------------------------------------------
// i2c_target_responder
//
// I2C target that watches one lane of a multi-lane open-drain bus, answers
// a single 7-bit address, stores every written byte in a 16-entry circular
// buffer and plays the buffer back on reads (loopback). SCL is never
// stretched.
//
// Ports
//   clk_i   : system clock, all logic on the rising edge
//   rst_i   : synchronous active-high reset
//   scl_i   : SCL level of every lane (only lane BUS_SEL is used)
//   sda_i   : SDA level of every lane (only lane BUS_SEL is used)
//   scl_o   : SCL drive, permanently high-impedance
//   sda_o   : SDA drive; lane BUS_SEL is 1'b0 when pulling low, otherwise
//             every bit is high-impedance
// ---------------------------------------------------------------------------
module i2c_target_responder #(
  parameter int                        NUM_BUSSES     = 16,
  parameter int                        BUS_SEL        = 0,
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_BUSSES-1:0] scl_i,
  input  logic [NUM_BUSSES-1:0] sda_i,
  output logic [NUM_BUSSES-1:0] scl_o,
  output logic [NUM_BUSSES-1:0] sda_o
);

  localparam int          DW        = I2C_DATA_WIDTH;
  localparam int          DEPTH     = 16;
  localparam logic [3:0]  BYTE_BITS = 4'(I2C_DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // Input conditioning: two synchronizer flops plus a previous-cycle copy
  // used for edge detection.
  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  state_t          r_state;
  logic [3:0]      r_bit_cnt;
  logic [DW-1:0]   r_shift;
  logic            r_rw;
  logic            r_sda_low;
  logic [3:0]      r_wr_ptr;
  logic [3:0]      r_rd_ptr;
  logic [DW-1:0]   r_buf [0:DEPTH-1];

  logic            w_scl_rise;
  logic            w_scl_fall;
  logic            w_start;
  logic            w_stop;
  logic            w_addr_match;
  logic [DW-1:0]   w_rd_byte;
  logic            w_unused_lanes;

  assign w_scl_rise   =  r_scl_sync & ~r_scl_prev;
  assign w_scl_fall   = ~r_scl_sync &  r_scl_prev;
  // START / STOP: SDA moves while SCL is (and stays) high.
  assign w_start      =  r_scl_sync & r_scl_prev & ~r_sda_sync &  r_sda_prev;
  assign w_stop       =  r_scl_sync & r_scl_prev &  r_sda_sync & ~r_sda_prev;
  assign w_addr_match = (r_shift[DW-1:1] == TARGET_ADDR);
  assign w_rd_byte    = r_buf[r_rd_ptr];

  // Only lane BUS_SEL is observed; the other lanes are intentionally ignored.
  assign w_unused_lanes = ^{scl_i, sda_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_sda_low  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_scl_meta <= scl_i[BUS_SEL];
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= sda_i[BUS_SEL];
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;

      // START / STOP win over any bit handling in the same cycle.
      if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= '0;
        r_sda_low <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_low <= 1'b0;
          end

          // Address phase: seven address bits followed by R/W.
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[DW-2:0], r_sda_sync};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == BYTE_BITS)) begin
              r_bit_cnt <= '0;
              r_rw      <= r_shift[0];
              if (w_addr_match) begin
                r_sda_low <= 1'b1;
                r_state   <= ST_ADDR_ACK;
              end else begin
                r_sda_low <= 1'b0;
                r_state   <= ST_WAIT_STOP;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_rw) begin
                r_sda_low <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= ST_WR_DATA;
              end else begin
                // MSB goes out immediately; r_bit_cnt counts bits already
                // placed on the bus.
                r_shift   <= w_rd_byte;
                r_sda_low <= ~w_rd_byte[DW-1];
                r_bit_cnt <= 4'd1;
                r_state   <= ST_RD_DATA;
              end
            end
          end

          ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[DW-2:0], r_sda_sync};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == BYTE_BITS)) begin
              r_buf[r_wr_ptr] <= r_shift;
              r_wr_ptr        <= r_wr_ptr + 4'd1;
              r_bit_cnt       <= '0;
              r_sda_low       <= 1'b1;
              r_state         <= ST_WR_ACK;
            end
          end

          ST_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= ST_WR_DATA;
            end
          end

          // r_shift[DW-1] is the bit currently on the bus; the next bit
          // sits just below it.
          ST_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == BYTE_BITS) begin
                r_sda_low <= 1'b0;
                r_rd_ptr  <= r_rd_ptr + 4'd1;
                r_bit_cnt <= '0;
                r_state   <= ST_RD_ACK;
              end else begin
                r_sda_low <= ~r_shift[DW-2];
                r_shift   <= {r_shift[DW-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          // A NACK ends the read at once; an ACK lets the following SCL
          // fall start the next byte.
          ST_RD_ACK: begin
            if (w_scl_rise) begin
              if (r_sda_sync) begin
                r_sda_low <= 1'b0;
                r_state   <= ST_WAIT_STOP;
              end
            end else if (w_scl_fall) begin
              r_shift   <= w_rd_byte;
              r_sda_low <= ~w_rd_byte[DW-1];
              r_bit_cnt <= 4'd1;
              r_state   <= ST_RD_DATA;
            end
          end

          ST_WAIT_STOP: begin
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  // Open-drain drive: only the monitored lane can ever pull SDA low.
  for (genvar g = 0; g < NUM_BUSSES; g++) begin : g_lane
    if (g == BUS_SEL) begin : g_sel
      assign sda_o[g] = r_sda_low ? 1'b0 : 1'bz;
    end else begin : g_idle
      assign sda_o[g] = 1'bz;
    end
  end

  assign scl_o = {NUM_BUSSES{1'bz}};

endmodule

// File: tb/tb_i2c_target_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_responder
//
// Directed bench: an I2C master model drives lane SEL of the bus, the
// DUT's open-drain outputs are resolved with pull-ups, and every expected
// value is written out by hand next to the step that produces it.
// ---------------------------------------------------------------------------
module tb_i2c_target_responder;

  localparam int NB  = 16;
  localparam int SEL = 3;
  localparam int Q   = 10;   // clk cycles per quarter SCL period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m_scl;
  logic          m_sda;
  logic [NB-1:0] scl_in;
  logic [NB-1:0] sda_in;
  wire  [NB-1:0] scl_out;
  wire  [NB-1:0] sda_out;
  wire           sda_lane;

  for (genvar g = 0; g < NB; g++) begin : g_pu
    pullup (sda_out[g]);
    pullup (scl_out[g]);
  end

  assign sda_lane = m_sda & sda_out[SEL];

  always_comb begin
    scl_in      = '1;
    scl_in[SEL] = m_scl;
    sda_in      = '1;
    sda_in[SEL] = sda_lane;
  end

  i2c_target_responder #(
    .NUM_BUSSES    (NB),
    .BUS_SEL       (SEL),
    .I2C_ADDR_WIDTH(7),
    .I2C_DATA_WIDTH(8),
    .TARGET_ADDR   (7'h22)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .scl_i (scl_in),
    .sda_i (sda_in),
    .scl_o (scl_out),
    .sda_o (sda_out)
  );

  int pull_cycles = 0;
  always @(posedge clk) begin
    if (sda_out[SEL] === 1'b0) pull_cycles <= pull_cycles + 1;
  end

  int            n_vec = 0;
  int            n_err = 0;
  logic [NB-1:0] last_sda_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_sda = b;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    s          = sda_lane;
    last_sda_o = sda_out;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(nack, s);
  endtask

  initial begin
    logic       ack;
    logic       all_ack;
    logic [7:0] d;
    logic       s;
    int         pull_base;

    rst   = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);

    // Reset state
    chk("rst_state",  dut.r_state,  3'd0);
    chk("rst_wr_ptr", dut.r_wr_ptr, 4'd0);
    chk("rst_rd_ptr", dut.r_rd_ptr, 4'd0);
    chk("rst_buf5",   dut.r_buf[5], 8'h00);
    chk("rst_sda_o",  sda_out,      16'hFFFF);
    chk("rst_scl_o",  scl_out,      16'hFFFF);

    // Write: 0x44, 0xA5, 0x3C
    i2c_start();
    write_byte(8'h44, ack);
    chk("wr_addr_ack", ack, 1'b1);
    chk("wr_ack_lane", last_sda_o, 16'hFFF7);
    write_byte(8'hA5, ack);
    chk("wr_d0_ack", ack, 1'b1);
    write_byte(8'h3C, ack);
    chk("wr_d1_ack", ack, 1'b1);
    i2c_stop();
    chk("wr_buf0",   dut.r_buf[0], 8'hA5);
    chk("wr_buf1",   dut.r_buf[1], 8'h3C);
    chk("wr_wr_ptr", dut.r_wr_ptr, 4'd2);
    chk("wr_state",  dut.r_state,  3'd0);

    // Read loopback
    i2c_start();
    write_byte(8'h45, ack);
    chk("rd_addr_ack", ack, 1'b1);
    read_byte(1'b0, d);
    chk("rd_byte0", d, 8'hA5);
    read_byte(1'b1, d);
    chk("rd_byte1", d, 8'h3C);
    tick(4);
    chk("rd_nack_state", dut.r_state, 3'd7);
    chk("rd_nack_sda",   sda_out[SEL], 1'b1);
    i2c_stop();
    chk("rd_rd_ptr", dut.r_rd_ptr, 4'd2);

    // Address mismatch
    pull_base = pull_cycles;
    i2c_start();
    write_byte(8'h46, ack);
    chk("mm_addr_ack", ack, 1'b0);
    write_byte(8'hFF, ack);
    chk("mm_data_ack", ack, 1'b0);
    i2c_stop();
    chk("mm_no_pull", pull_cycles - pull_base, 0);
    chk("mm_wr_ptr",  dut.r_wr_ptr, 4'd2);
    chk("mm_rd_ptr",  dut.r_rd_ptr, 4'd2);
    chk("mm_buf2",    dut.r_buf[2], 8'h00);

    // Repeated START: write 0x11 into buf[2], then read it back from rd_ptr=2
    i2c_start();
    write_byte(8'h44, ack);
    chk("sr_addr_ack", ack, 1'b1);
    write_byte(8'h11, ack);
    chk("sr_data_ack", ack, 1'b1);
    i2c_start();
    write_byte(8'h45, ack);
    chk("sr_raddr_ack", ack, 1'b1);
    read_byte(1'b1, d);
    chk("sr_rd_byte", d, 8'h11);
    i2c_stop();
    chk("sr_state",  dut.r_state,  3'd0);
    chk("sr_rd_ptr", dut.r_rd_ptr, 4'd3);
    chk("sr_wr_ptr", dut.r_wr_ptr, 4'd3);

    // Reset during bit 4 of a data byte (0xA5: bits 1,0,1,0 ...)
    i2c_start();
    write_byte(8'h44, ack);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q / 2);
    rst = 1'b1;
    tick(1);
    chk("mr_sda",    sda_out[SEL], 1'b1);
    chk("mr_state",  dut.r_state,  3'd0);
    chk("mr_wr_ptr", dut.r_wr_ptr, 4'd0);
    chk("mr_rd_ptr", dut.r_rd_ptr, 4'd0);
    chk("mr_buf0",   dut.r_buf[0], 8'h00);
    rst = 1'b0;
    tick(Q / 2);
    m_scl = 1'b0;
    tick(Q);
    i2c_stop();
    chk("mr_idle", dut.r_state, 3'd0);
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h5A, ack);
    chk("mr_post_ack", ack, 1'b1);
    i2c_stop();
    chk("mr_post_buf0", dut.r_buf[0], 8'h5A);
    chk("mr_post_wr",   dut.r_wr_ptr, 4'd1);

    // Wrap-around: fresh reset, write 0x00..0x10, read 16
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    i2c_start();
    write_byte(8'h44, ack);
    all_ack = ack;
    for (int i = 0; i <= 16; i++) begin
      write_byte(8'(i), ack);
      all_ack = all_ack & ack;
    end
    i2c_stop();
    chk("wrap_acks",   all_ack,       1'b1);
    chk("wrap_wr_ptr", dut.r_wr_ptr,  4'd1);
    chk("wrap_buf0",   dut.r_buf[0],  8'h10);
    chk("wrap_buf1",   dut.r_buf[1],  8'h01);
    chk("wrap_buf15",  dut.r_buf[15], 8'h0F);
    i2c_start();
    write_byte(8'h45, ack);
    chk("wrap_raddr_ack", ack, 1'b1);
    for (int i = 0; i < 16; i++) begin
      read_byte(i == 15, d);
      chk($sformatf("wrap_rd%0d", i), d, (i == 0) ? 32'h10 : 32'(i));
    end
    i2c_stop();
    chk("wrap_rd_ptr", dut.r_rd_ptr, 4'd0);
    chk("wrap_state",  dut.r_state,  3'd0);
    chk("end_sda_o",   sda_out,      16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
